// File: rtl/soc2_ram_arb_pkg.sv
// Shared types and defaults for the SoC2 two-port RAM arbiter.
// Optional build macro: SOC2_RAM_ARB_FIXED_PRIO_EN (see soc2_ram_arb_grant).
package soc2_ram_arb_pkg;

  localparam int ADDR_W_DEF = 9;
  localparam int DATA_W_DEF = 32;

  typedef logic [0:0] port_idx_t;

  // last_grant starts on port 1 so that port 0 wins the first tie.
  localparam port_idx_t LAST_GRANT_RST = 1'b1;

endpackage

// File: rtl/soc2_ram_arbiter_if.sv
// Avalon-MM bundle between the two requesters, the arbiter and the RAM s1 slave.
// slave = arbiter view; master = environment view (requesters plus RAM).
interface soc2_ram_arbiter_if #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0]   m0_address,    m1_address;
  logic [DATA_W/8-1:0] m0_byteenable, m1_byteenable;
  logic                m0_read,       m1_read;
  logic                m0_write,      m1_write;
  logic [DATA_W-1:0]   m0_writedata,  m1_writedata;
  logic                m0_waitrequest,   m1_waitrequest;
  logic [DATA_W-1:0]   m0_readdata,      m1_readdata;
  logic                m0_readdatavalid, m1_readdatavalid;

  logic [ADDR_W-1:0]   ram_address;
  logic [DATA_W/8-1:0] ram_byteenable;
  logic                ram_chipselect;
  logic                ram_write;
  logic [DATA_W-1:0]   ram_writedata;
  logic                ram_clken;
  logic [DATA_W-1:0]   ram_readdata;

  modport slave (
    input  m0_address, m0_byteenable, m0_read, m0_write, m0_writedata,
    input  m1_address, m1_byteenable, m1_read, m1_write, m1_writedata,
    output m0_waitrequest, m0_readdata, m0_readdatavalid,
    output m1_waitrequest, m1_readdata, m1_readdatavalid,
    output ram_address, ram_byteenable, ram_chipselect, ram_write,
    output ram_writedata, ram_clken,
    input  ram_readdata
  );

  modport master (
    output m0_address, m0_byteenable, m0_read, m0_write, m0_writedata,
    output m1_address, m1_byteenable, m1_read, m1_write, m1_writedata,
    input  m0_waitrequest, m0_readdata, m0_readdatavalid,
    input  m1_waitrequest, m1_readdata, m1_readdatavalid,
    input  ram_address, ram_byteenable, ram_chipselect, ram_write,
    input  ram_writedata, ram_clken,
    output ram_readdata
  );

endinterface

// File: rtl/soc2_ram_arb_grant.sv
// Two-way combinational grant with a 1-bit round-robin history register.
// With SOC2_RAM_ARB_FIXED_PRIO_EN defined, port 0 always wins and no history is kept.
module soc2_ram_arb_grant
  import soc2_ram_arb_pkg::*;
(
  input  logic      clk,
  input  logic      reset,
  input  logic [1:0] req_i,
  output logic      gnt_valid_o,
  output port_idx_t gnt_idx_o
);

`ifdef SOC2_RAM_ARB_FIXED_PRIO_EN

  logic unused_clk_rst;
  assign unused_clk_rst = clk ^ reset;

  always_comb begin
    gnt_valid_o = |req_i;
    gnt_idx_o   = (req_i[0] || !req_i[1]) ? 1'b0 : 1'b1;
  end

`else

  port_idx_t last_grant_q, last_grant_d;

  always_comb begin
    gnt_valid_o  = |req_i;
    gnt_idx_o    = 1'b0;
    if (&req_i) begin
      gnt_idx_o = ~last_grant_q;
    end else if (req_i[1]) begin
      gnt_idx_o = 1'b1;
    end
    last_grant_d = gnt_valid_o ? gnt_idx_o : last_grant_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant_q <= LAST_GRANT_RST;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end

`endif

endmodule

// File: rtl/soc2_ram_arbiter.sv
// Arbiter top: RAM request mux, per-port waitrequest and the one-cycle readdatavalid pipe.
// Grant policy selected by SOC2_RAM_ARB_FIXED_PRIO_EN (default round-robin).
module soc2_ram_arbiter
  import soc2_ram_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic               clk,
  input  logic               reset,
  soc2_ram_arbiter_if.slave  bus
);

  logic [1:0] rd, wr, req, granted, wait_w, rdv;
  logic [1:0] rd_pend_q, rd_pend_d;
  logic       gnt_valid, accept;
  port_idx_t  gnt_idx, sel;

  logic [ADDR_W-1:0]   addr_mux;
  logic [DATA_W/8-1:0] be_mux;
  logic [DATA_W-1:0]   wdata_mux;
  logic                write_mux;

  assign rd  = {bus.m1_read,  bus.m0_read};
  assign wr  = {bus.m1_write, bus.m0_write};
  assign req = rd | wr;

  soc2_ram_arb_grant u_grant (
    .clk         (clk),
    .reset       (reset),
    .req_i       (req),
    .gnt_valid_o (gnt_valid),
    .gnt_idx_o   (gnt_idx)
  );

  // Nothing is accepted while reset is held, whatever the grant logic says.
  assign accept = gnt_valid & ~reset;
  assign sel    = accept ? gnt_idx : 1'b0;

  assign addr_mux  = (sel == 1'b1) ? bus.m1_address    : bus.m0_address;
  assign be_mux    = (sel == 1'b1) ? bus.m1_byteenable : bus.m0_byteenable;
  assign wdata_mux = (sel == 1'b1) ? bus.m1_writedata  : bus.m0_writedata;
  assign write_mux = (sel == 1'b1) ? bus.m1_write      : bus.m0_write;

  assign bus.ram_address    = addr_mux;
  assign bus.ram_byteenable = be_mux;
  assign bus.ram_writedata  = wdata_mux;
  assign bus.ram_chipselect = accept;
  assign bus.ram_write      = accept & write_mux;
  assign bus.ram_clken      = 1'b1;

  for (genvar gi = 0; gi < 2; gi++) begin : g_port
    assign granted[gi]   = accept & (gnt_idx == port_idx_t'(gi));
    assign wait_w[gi]    = reset | (req[gi] & ~granted[gi]);
    // Read+write on one port counts as a write and produces no response.
    assign rd_pend_d[gi] = granted[gi] & rd[gi] & ~wr[gi];
    assign rdv[gi]       = rd_pend_q[gi] & ~reset;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_pend_q <= '0;
    end else begin
      rd_pend_q <= rd_pend_d;
    end
  end

  assign bus.m0_waitrequest   = wait_w[0];
  assign bus.m1_waitrequest   = wait_w[1];
  assign bus.m0_readdatavalid = rdv[0];
  assign bus.m1_readdatavalid = rdv[1];
  assign bus.m0_readdata      = bus.ram_readdata;
  assign bus.m1_readdata      = bus.ram_readdata;

endmodule

// File: tb/tb_soc2_ram_arbiter.sv
// Bench for soc2_ram_arbiter: RAM model, per-cycle reference model and directed scenarios.
// Honours SOC2_RAM_ARB_FIXED_PRIO_EN for the contention expectations.
`timescale 1ns/1ps
module tb_soc2_ram_arbiter;

  localparam int AW = 9;
  localparam int DW = 32;
  localparam int BW = DW / 8;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  soc2_ram_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  soc2_ram_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  // RAM s1 behaviour: registered address, unregistered q.
  logic [DW-1:0] ram_mem [512];
  logic [AW-1:0] ram_addr_q;
  initial for (int i = 0; i < 512; i++) ram_mem[i] = '0;
  always @(posedge clk) begin
    if (bus.ram_chipselect && bus.ram_write && bus.ram_clken)
      for (int b = 0; b < BW; b++)
        if (bus.ram_byteenable[b]) ram_mem[bus.ram_address][8*b +: 8] <= bus.ram_writedata[8*b +: 8];
    ram_addr_q <= bus.ram_address;
  end
  assign bus.ram_readdata = ram_mem[ram_addr_q];

  // Reference model: who won last, which port has a read coming back, shadow contents.
  logic [DW-1:0] shadow [512];
  initial for (int i = 0; i < 512; i++) shadow[i] = '0;
  int            m_last = 1;
  int            m_pend = -1;
  logic [DW-1:0] m_pend_data;

  int            c_win, c_nxt;
  logic          c_req0, c_req1, c_rd, c_wr;
  logic [AW-1:0] c_a;
  logic [BW-1:0] c_be;
  logic [DW-1:0] c_d;

  always @(negedge clk) begin : cmp
    c_req0 = bus.m0_read | bus.m0_write;
    c_req1 = bus.m1_read | bus.m1_write;
    check("clken", bus.ram_clken, 1);
    if (reset) begin
      check("rst_wait0", bus.m0_waitrequest, 1);
      check("rst_wait1", bus.m1_waitrequest, 1);
      check("rst_cs", bus.ram_chipselect, 0);
      check("rst_wr", bus.ram_write, 0);
      check("rst_rdv0", bus.m0_readdatavalid, 0);
      check("rst_rdv1", bus.m1_readdatavalid, 0);
      m_last = 1;
      m_pend = -1;
    end else begin
      if (c_req0 && c_req1) begin
`ifdef SOC2_RAM_ARB_FIXED_PRIO_EN
        c_win = 0;
`else
        c_win = 1 - m_last;
`endif
      end else if (c_req0) c_win = 0;
      else if (c_req1) c_win = 1;
      else c_win = -1;

      check("wait0", bus.m0_waitrequest, (c_req0 && c_win != 0) ? 1 : 0);
      check("wait1", bus.m1_waitrequest, (c_req1 && c_win != 1) ? 1 : 0);
      check("cs", bus.ram_chipselect, (c_win >= 0) ? 1 : 0);
      check("rdv0", bus.m0_readdatavalid, (m_pend == 0) ? 1 : 0);
      check("rdv1", bus.m1_readdatavalid, (m_pend == 1) ? 1 : 0);
      if (m_pend >= 0) begin
        check("rdata0", bus.m0_readdata, m_pend_data);
        check("rdata1", bus.m1_readdata, m_pend_data);
      end
      c_nxt = -1;
      if (c_win >= 0) begin
        c_rd = (c_win == 0) ? bus.m0_read       : bus.m1_read;
        c_wr = (c_win == 0) ? bus.m0_write      : bus.m1_write;
        c_a  = (c_win == 0) ? bus.m0_address    : bus.m1_address;
        c_be = (c_win == 0) ? bus.m0_byteenable : bus.m1_byteenable;
        c_d  = (c_win == 0) ? bus.m0_writedata  : bus.m1_writedata;
        check("ram_addr", 32'(bus.ram_address), 32'(c_a));
        check("ram_write", bus.ram_write, c_wr);
        if (c_wr) begin
          check("ram_be", 32'(bus.ram_byteenable), 32'(c_be));
          check("ram_wdata", bus.ram_writedata, c_d);
          for (int b = 0; b < BW; b++) if (c_be[b]) shadow[c_a][8*b +: 8] = c_d[8*b +: 8];
          $display("[%0t] m%0d write addr=%h be=%h data=%h", $time, c_win, c_a, c_be, c_d);
        end else if (c_rd) begin
          c_nxt       = c_win;
          m_pend_data = shadow[c_a];
          $display("[%0t] m%0d read  addr=%h expect=%h", $time, c_win, c_a, shadow[c_a]);
        end
        m_last = c_win;
      end else begin
        check("ram_write_idle", bus.ram_write, 0);
      end
      m_pend = c_nxt;
    end
  end

  // One cycle of stimulus; returns at the following falling edge.
  task automatic drive(input logic rst,
                       input logic r0, input logic w0, input logic [AW-1:0] a0,
                       input logic [BW-1:0] be0, input logic [DW-1:0] d0,
                       input logic r1, input logic w1, input logic [AW-1:0] a1,
                       input logic [BW-1:0] be1, input logic [DW-1:0] d1);
    @(posedge clk);
    #1;
    reset = rst;
    bus.m0_read = r0; bus.m0_write = w0; bus.m0_address = a0;
    bus.m0_byteenable = be0; bus.m0_writedata = d0;
    bus.m1_read = r1; bus.m1_write = w1; bus.m1_address = a1;
    bus.m1_byteenable = be1; bus.m1_writedata = d1;
    @(negedge clk);
  endtask

  task automatic idle(input logic rst);
    drive(rst, 0, 0, '0, '0, '0, 0, 0, '0, '0, '0);
  endtask

  int rdv_cnt0, rdv_cnt1;

  initial begin
    reset = 1'b1;
    bus.m0_read = 0; bus.m0_write = 0; bus.m0_address = '0; bus.m0_byteenable = '0; bus.m0_writedata = '0;
    bus.m1_read = 0; bus.m1_write = 0; bus.m1_address = '0; bus.m1_byteenable = '0; bus.m1_writedata = '0;
    idle(1);
    idle(1);
    check("lit_rst_wait0", bus.m0_waitrequest, 1);

    // m0 write then read of 0x010.
    drive(0, 0, 1, 9'h010, 4'hF, 32'hDEADBEEF, 0, 0, '0, '0, '0);
    check("lit_t1_wr_wait0", bus.m0_waitrequest, 0);
    drive(0, 1, 0, 9'h010, 4'hF, '0, 0, 0, '0, '0, '0);
    check("lit_t1_rd_wait0", bus.m0_waitrequest, 0);
    check("lit_t1_rdv_early", bus.m0_readdatavalid, 0);
    idle(0);
    check("lit_t1_rdv0", bus.m0_readdatavalid, 1);
    check("lit_t1_rdata", bus.m0_readdata, 32'hDEADBEEF);
    idle(0);
    check("lit_t1_rdv_late", bus.m0_readdatavalid, 0);

    // m1 partial write over all-ones.
    drive(0, 0, 0, '0, '0, '0, 0, 1, 9'h1FF, 4'hF, 32'hFFFFFFFF);
    drive(0, 0, 0, '0, '0, '0, 0, 1, 9'h1FF, 4'h5, 32'h11223344);
    drive(0, 0, 0, '0, '0, '0, 1, 0, 9'h1FF, 4'hF, '0);
    idle(0);
    check("lit_t2_rdv1", bus.m1_readdatavalid, 1);
    check("lit_t2_rdata", bus.m1_readdata, 32'hFF22FF44);

    // Contention from reset.
    drive(1, 1, 0, 9'h010, 4'hF, '0, 1, 0, 9'h1FF, 4'hF, '0);
    rdv_cnt0 = 0; rdv_cnt1 = 0;
`ifdef SOC2_RAM_ARB_FIXED_PRIO_EN
    for (int k = 0; k < 4; k++) begin
      drive(0, 1, 0, 9'h010, 4'hF, '0, 1, 0, 9'h1FF, 4'hF, '0);
      check("lit_fp_wait0", bus.m0_waitrequest, 0);
      check("lit_fp_wait1", bus.m1_waitrequest, 1);
    end
    idle(0);
`else
    for (int k = 0; k < 7; k++) begin
      if (k < 6) begin
        drive(0, 1, 0, 9'h010, 4'hF, '0, 1, 0, 9'h1FF, 4'hF, '0);
        check("lit_rr_wait0", bus.m0_waitrequest, (k % 2 == 1) ? 1 : 0);
        check("lit_rr_wait1", bus.m1_waitrequest, (k % 2 == 0) ? 1 : 0);
      end else begin
        idle(0);
      end
      if (bus.m0_readdatavalid === 1'b1) begin
        rdv_cnt0++;
        check("lit_rr_rdata0", bus.m0_readdata, 32'hDEADBEEF);
      end
      if (bus.m1_readdatavalid === 1'b1) begin
        rdv_cnt1++;
        check("lit_rr_rdata1", bus.m1_readdata, 32'hFF22FF44);
      end
    end
    check("lit_rr_cnt0", rdv_cnt0, 3);
    check("lit_rr_cnt1", rdv_cnt1, 3);
`endif

    // Simultaneous m0 write / m1 read of 0x020 with last_grant at reset value.
    idle(1);
    drive(0, 0, 1, 9'h020, 4'hF, 32'hCAFEF00D, 1, 0, 9'h020, 4'hF, '0);
    check("lit_t4_wait0", bus.m0_waitrequest, 0);
    check("lit_t4_wait1", bus.m1_waitrequest, 1);
    drive(0, 0, 0, '0, '0, '0, 1, 0, 9'h020, 4'hF, '0);
    check("lit_t4_wait1b", bus.m1_waitrequest, 0);
    idle(0);
    check("lit_t4_rdata", bus.m1_readdata, 32'hCAFEF00D);

    // Read then write of the same word on consecutive cycles returns old data.
    drive(0, 1, 0, 9'h020, 4'hF, '0, 0, 0, '0, '0, '0);
    drive(0, 0, 0, '0, '0, '0, 0, 1, 9'h020, 4'hF, 32'h55AA55AA);
    check("lit_rw_old", bus.m0_readdata, 32'hCAFEF00D);
    drive(0, 1, 0, 9'h020, 4'hF, '0, 0, 0, '0, '0, '0);
    idle(0);
    check("lit_rw_new", bus.m0_readdata, 32'h55AA55AA);

    // Reset right after an accepted m1 read drops the response.
    drive(0, 0, 0, '0, '0, '0, 1, 0, 9'h1FF, 4'hF, '0);
    check("lit_t5_wait1", bus.m1_waitrequest, 0);
    drive(1, 1, 0, 9'h010, 4'hF, '0, 1, 0, 9'h1FF, 4'hF, '0);
    check("lit_t5_rdv1", bus.m1_readdatavalid, 0);
    check("lit_t5_rst_wait0", bus.m0_waitrequest, 1);
    check("lit_t5_rst_wait1", bus.m1_waitrequest, 1);
    drive(0, 1, 0, 9'h010, 4'hF, '0, 1, 0, 9'h1FF, 4'hF, '0);
    check("lit_t5_tie_wait0", bus.m0_waitrequest, 0);
    check("lit_t5_tie_wait1", bus.m1_waitrequest, 1);
    idle(0);
    idle(0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/soc2_ram_arbiter.md
# soc2_ram_arbiter

Two-requester Avalon-MM arbiter sharing the single-port 512x32 on-chip RAM of the SoC2 system. It issues at most one RAM access per cycle. Arbitration is round-robin and combinational, with per-port waitrequest backpressure and a one-cycle readdatavalid. It sits between two masters (e.g. CPU data port and a DMA engine) and the RAM's s1 slave, so the RAM itself stays unmodified.

## Interface
Parameters:
- ADDR_W, 9, RAM word-address width (512 words)
- DATA_W, 32, data width; byte-enable width is DATA_W/8

Ports:
- clk  in  1  system clock; all logic on rising edge
- reset  in  1  synchronous, active-high reset
- m0_address / m1_address  in  ADDR_W  word address per requester
- m0_byteenable / m1_byteenable  in  DATA_W/8  byte lanes for writes
- m0_read / m1_read  in  1  read request
- m0_write / m1_write  in  1  write request
- m0_writedata / m1_writedata  in  DATA_W  write data
- m0_waitrequest / m1_waitrequest  out  1  request not accepted this cycle
- m0_readdata / m1_readdata  out  DATA_W  read data, qualified by readdatavalid
- m0_readdatavalid / m1_readdatavalid  out  1  readdata valid this cycle
- ram_address  out  ADDR_W  to RAM
- ram_byteenable  out  DATA_W/8  to RAM
- ram_chipselect  out  1  to RAM
- ram_write  out  1  to RAM
- ram_writedata  out  DATA_W  to RAM
- ram_clken  out  1  to RAM; constant 1
- ram_readdata  in  DATA_W  from RAM; unregistered q; valid one cycle after address is issued

## Operation
- req_i = mi_read | mi_write. If both read and write are high on one port, the access is a write, and no readdatavalid follows.
- Grant is computed combinationally each cycle from req0, req1 and the 1-bit register last_grant.
  - Only one requester: it is granted.
  - Both requesters: the port != last_grant is granted.
  - Neither: no grant.
- last_grant loads the granted index on every cycle with a grant and holds otherwise.
- Granted port:
  - its address, byteenable and writedata drive the RAM
  - ram_chipselect = 1
  - ram_write = its write
  - its waitrequest = 0
- Non-granted requesting port: waitrequest = 1. It must hold its signals stable (Avalon rule). A port that is not requesting has waitrequest = 0.
- No grant: ram_chipselect = 0, ram_write = 0. Address and data mux to port 0 (don't-care).
- rd_pend_i (registered) <= granted_i & mi_read & ~mi_write.
  - mi_readdatavalid = rd_pend_i.
  - Both mi_readdata = ram_readdata (broadcast).
- Throughput: one access per cycle. A single continuously requesting port gets 100%. Two contending ports alternate every cycle.

## Timing
- Reset values (reset high, sampled on clk):
  - last_grant = 1, so m0 wins the first tie
  - rd_pend_0/1 = 0
- While reset is high:
  - both waitrequests forced to 1
  - ram_chipselect = 0, ram_write = 0
  - readdatavalid = 0
- Read latency: accepted in cycle N -> readdatavalid high in cycle N+1 only.
- Write: completes in the accept cycle; no response.
- Reset asserted one cycle after an accepted read: the pending readdatavalid is dropped (0 in the reset cycle).
- Read then write to the same address in consecutive cycles: the read returns the old data (RAM registered address, unregistered output).
- Back-to-back reads: readdatavalid may stay high every cycle. Each cycle's data corresponds to the previous cycle's accepted address.

## Configuration
- SOC2_RAM_ARB_FIXED_PRIO_EN
  - Defined: m0 always wins contention and last_grant is not implemented. m1 may starve while m0 requests continuously.
  - Undefined (default): round-robin as described in Operation.

## Structure
- Package soc2_ram_arb_pkg holds:
  - ADDR_W/DATA_W defaults
  - typedef for port index (1 bit)
  - localparam for the reset value of last_grant
- Sub-module soc2_ram_arb_grant holds the 2-way grant logic and the last_grant register (or the fixed-priority variant under the macro).
- The top level holds the muxes, waitrequest and readdatavalid pipeline.

## Test plan
- m0 write 0xDEADBEEF to addr 0x010 with be=0xF, then m0 read 0x010 -> waitrequest 0 both cycles; readdatavalid one cycle after the read with readdata 0xDEADBEEF.
- m1 write 0x11223344 to addr 0x1FF with be=0x5 over a prior 0xFFFFFFFF, then read -> 0xFF22FF44.
- m0 and m1 both read continuously from reset for 6 cycles -> grants m0, m1, m0, m1, m0, m1; each waitrequest high in alternate cycles; each port sees 3 readdatavalid pulses with correct data.
- Simultaneous m0 write to 0x020 and m1 read from 0x020 with last_grant=1 -> m0 writes first; m1's read, granted next cycle, returns the new value.
- Reset asserted the cycle after an accepted m1 read -> m1_readdatavalid stays 0; both waitrequests are 1 during reset; after release, the first tie goes to m0.
- With SOC2_RAM_ARB_FIXED_PRIO_EN defined and both ports requesting for 4 cycles -> m0 is granted all 4 and m1_waitrequest stays 1 throughout.
